muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the RD1/RD2 operand pair, computes one of the eight M-extension operations over multiple cycles, and raises BUSY_o to stall the pipeline while it works. On completion it drives a one-cycle write (address, data, enable) that feeds the register file's AD3/WD3/WE3 write port.

## Interface
- DATA_WIDTH, 32: operand and result width.
- ADDRESS_WIDTH, 5: destination register address width.
- clk  input  1  clock; all state updates on its rising edge.
- RST_N_i  input  1  reset; asynchronous, active-low.
- START_i  input  1  request; accepted only in IDLE.
- FUNCT3_i  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OP_A_i  input  DATA_WIDTH  rs1 value (register file RD1).
- OP_B_i  input  DATA_WIDTH  rs2 value (register file RD2).
- RD_ADDR_i  input  ADDRESS_WIDTH  destination register.
- FLUSH_i  input  1  abort the in-flight operation.
- BUSY_o  output  1  high whenever state is not IDLE; pipeline stall.
- DONE_o  output  1  one-cycle completion pulse.
- RESULT_o  output  DATA_WIDTH  result; holds until the next accepted START; to WD3.
- WE_o  output  1  write enable to WE3; equals DONE_o AND (rd != 0).
- RD_ADDR_o  output  ADDRESS_WIDTH  latched rd; to AD3.

## Operation
- FSM states: IDLE, CALC, FINISH.
  - IDLE→CALC on START_i, for the normal path.
  - IDLE→FINISH on START_i, for special cases and for fast multiply.
  - CALC→FINISH when the iteration counter reaches 0.
  - FINISH→IDLE unconditionally.
- On acceptance:
  - Latch funct3 and rd.
  - Latch operand magnitudes: the absolute value for signed-treated operands, raw otherwise. MULHSU treats only OP_A as signed.
  - Latch result sign flags.
  - Load counter with DATA_WIDTH-1.
- Multiply: shift-add, one bit of the multiplier per cycle, into a 2*DATA_WIDTH product. MUL returns the low half; MULH/MULHSU/MULHU return the high half. Negate the full product when the signs differ.
- Divide: radix-2 restoring, one quotient bit per cycle.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
  - Unsigned ops never negate.
- Special cases are resolved at acceptance and go straight to FINISH:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return OP_A.
  - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- FINISH state:
  - RESULT_o updates.
  - DONE_o = 1.
  - WE_o = 1 unless rd = 0.
- FLUSH_i in CALC or FINISH: return to IDLE next edge, with no DONE_o/WE_o; RESULT_o keeps its previous value.
- FLUSH_i and START_i together in IDLE: flush wins; the request is not accepted.
- START_i while not IDLE is ignored; operand changes while busy are ignored.

## Timing
- Reset values: state IDLE, BUSY_o 0, DONE_o 0, WE_o 0, RESULT_o 0, RD_ADDR_o 0, counter 0.
- Reset mid-operation aborts immediately, asynchronously.
- START_i accepted at edge t:
  - Iterative path: CALC occupies edges t+1..t+32; FINISH is the cycle after edge t+32. DONE_o is high for exactly one cycle, 33 cycles after the START cycle.
  - Special-case path: DONE_o is high in the cycle after the START cycle (latency 1).
- BUSY_o rises in the cycle after acceptance and stays high through the FINISH cycle. The write-back occurs in that FINISH cycle.
- A new START_i can be accepted in the cycle after FINISH at the earliest.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - All four multiply ops compute with a single combinational DATA_WIDTH×DATA_WIDTH product and go IDLE→FINISH, latency 1.
  - Divide is unchanged.
- Not defined: multiply uses the iterative path, latency 33.
- Results are bit-identical either way.

## Structure
- Shared package muldiv_pkg holds:
  - the funct3 op enum;
  - the FSM state enum (IDLE, CALC, FINISH);
  - constants for the divide-by-zero quotient and the overflow dividend.
- One sub-module, muldiv_div_core: the per-cycle restoring-divide step (remainder/quotient shift-subtract), instantiated by muldiv_unit.
- Sign handling and the FSM stay in muldiv_unit.

## Test plan
- MUL 7 × -3, rd = 5: DONE_o at cycle 33 (1 with MULDIV_FAST_MUL_EN), RESULT_o = 0xFFFFFFEB, WE_o = 1, RD_ADDR_o = 5.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE. MULH of the same operands gives 0. MULHSU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFF.
- DIV -7 / 2 gives 0xFFFFFFFD; REM -7 / 2 gives 0xFFFFFFFF; DIVU 100 / 7 gives 14; REMU 100 / 7 gives 2. Each asserts DONE at cycle 33.
- Divide by zero:
  - DIV 5 / 0 gives 0xFFFFFFFF.
  - REMU 5 / 0 gives 5.
  - Both assert DONE the cycle after START.
- Overflow: DIV 0x80000000 / -1 gives 0x80000000; REM of the same gives 0. Both have latency 1.
- Control:
  - FLUSH_i at cycle 10 of a DIV: BUSY_o drops next cycle, no DONE_o/WE_o.
  - START_i while busy is ignored.
  - rd = 0: DONE_o = 1, WE_o = 0.
  - RST_N_i low mid-CALC: all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_DIVIDEND  = 32'h8000_0000;
    localparam logic [31:0] OVF_DIVISOR   = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_if.sv
// Request/write-back bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     START_i;
    logic [2:0]               FUNCT3_i;
    logic [DATA_WIDTH-1:0]    OP_A_i;
    logic [DATA_WIDTH-1:0]    OP_B_i;
    logic [ADDRESS_WIDTH-1:0] RD_ADDR_i;
    logic                     FLUSH_i;
    logic                     BUSY_o;
    logic                     DONE_o;
    logic [DATA_WIDTH-1:0]    RESULT_o;
    logic                     WE_o;
    logic [ADDRESS_WIDTH-1:0] RD_ADDR_o;

    modport master (
        output START_i, FUNCT3_i, OP_A_i, OP_B_i, RD_ADDR_i, FLUSH_i,
        input  BUSY_o, DONE_o, RESULT_o, WE_o, RD_ADDR_o
    );

    modport slave (
        input  START_i, FUNCT3_i, OP_A_i, OP_B_i, RD_ADDR_i, FLUSH_i,
        output BUSY_o, DONE_o, RESULT_o, WE_o, RD_ADDR_o
    );
endinterface

// File: rtl/muldiv_div_core.sv
// One radix-2 restoring-divide step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module muldiv_div_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] quo_next
);
    logic [DATA_WIDTH:0] trial_s;

    // Trial subtraction; the low bits of the difference are exact because rem < divisor.
    always_comb begin
        trial_s = {rem, quo[DATA_WIDTH-1]};
        if (trial_s >= {1'b0, divisor}) begin
            rem_next = trial_s[DATA_WIDTH-1:0] - divisor;
            quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_next = trial_s[DATA_WIDTH-1:0];
            quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Defining MULDIV_FAST_MUL_EN computes all multiplies with one combinational product (latency 1).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input logic     clk,
    input logic     RST_N_i,
    muldiv_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    state_e                   state_r, state_nx_s;
    op_e                      op_s;
    logic [2:0]               op_r;
    logic [ADDRESS_WIDTH-1:0] rd_r, rd_nx_s;
    logic [DATA_WIDTH-1:0]    acc_r, lo_r, opb_r, result_r;
    logic [CNT_WIDTH-1:0]     cnt_r;
    logic                     neg_r, busy_r, done_r, we_r;
    logic                     accept_s, sign_a_s, sign_b_s, neg_s, div0_s, ovf_s, fast_s;
    logic [DATA_WIDTH-1:0]    mag_a_s, mag_b_s, early_result_s, fast_result_s;
    logic [DATA_WIDTH:0]      mul_sum_s;
    logic [DATA_WIDTH-1:0]    div_rem_s, div_quo_s, step_acc_s, step_lo_s, step_result_s;

    function automatic logic [DATA_WIDTH-1:0] mul_pick(input logic [2:0] op,
                                                       input logic [2*DATA_WIDTH-1:0] prod,
                                                       input logic neg);
        logic [2*DATA_WIDTH-1:0] p;
        p = neg ? -prod : prod;
        if (op == OP_MUL) mul_pick = p[DATA_WIDTH-1:0];
        else              mul_pick = p[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] div_pick(input logic [2:0] op,
                                                       input logic [DATA_WIDTH-1:0] quo,
                                                       input logic [DATA_WIDTH-1:0] rem,
                                                       input logic neg);
        logic [DATA_WIDTH-1:0] v;
        v = op[1] ? rem : quo;
        div_pick = neg ? -v : v;
    endfunction

    assign accept_s = (state_r == ST_IDLE) && bus.START_i && !bus.FLUSH_i;
    assign rd_nx_s  = accept_s ? bus.RD_ADDR_i : rd_r;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_WIDTH-1:0] fast_prod_s;
    assign fast_prod_s   = {{DATA_WIDTH{1'b0}}, mag_a_s} * {{DATA_WIDTH{1'b0}}, mag_b_s};
    assign fast_s        = ~bus.FUNCT3_i[2];
    assign fast_result_s = mul_pick(op_s, fast_prod_s, neg_s);
`else
    assign fast_s        = 1'b0;
    assign fast_result_s = {DATA_WIDTH{1'b0}};
`endif

    // Decode an incoming request: operand signs/magnitudes, special cases and the one-cycle result.
    always_comb begin
        op_s     = op_e'(bus.FUNCT3_i);
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        case (op_s)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                sign_a_s = bus.OP_A_i[DATA_WIDTH-1];
                sign_b_s = bus.OP_B_i[DATA_WIDTH-1];
            end
            OP_MULHSU: sign_a_s = bus.OP_A_i[DATA_WIDTH-1];
            default: begin
                sign_a_s = 1'b0;
                sign_b_s = 1'b0;
            end
        endcase
        mag_a_s = sign_a_s ? -bus.OP_A_i : bus.OP_A_i;
        mag_b_s = sign_b_s ? -bus.OP_B_i : bus.OP_B_i;
        neg_s   = (op_s == OP_REM) ? sign_a_s : (sign_a_s ^ sign_b_s);
        div0_s  = bus.FUNCT3_i[2] && (bus.OP_B_i == {DATA_WIDTH{1'b0}});
        ovf_s   = ((op_s == OP_DIV) || (op_s == OP_REM)) &&
                  (bus.OP_A_i == OVF_DIVIDEND) && (bus.OP_B_i == OVF_DIVISOR);
        if (div0_s)     early_result_s = bus.FUNCT3_i[1] ? bus.OP_A_i : DIV0_QUOTIENT;
        else if (ovf_s) early_result_s = bus.FUNCT3_i[1] ? {DATA_WIDTH{1'b0}} : OVF_DIVIDEND;
        else            early_result_s = fast_result_s;
    end

    assign mul_sum_s = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opb_r} : {(DATA_WIDTH+1){1'b0}});

    muldiv_div_core #(.DATA_WIDTH(DATA_WIDTH)) u_div_core (
        .rem      (acc_r),
        .quo      (lo_r),
        .divisor  (opb_r),
        .rem_next (div_rem_s),
        .quo_next (div_quo_s)
    );

    // One iteration step; acc/lo hold product high/low for multiply, remainder/quotient for divide.
    always_comb begin
        if (op_r[2]) begin
            step_acc_s    = div_rem_s;
            step_lo_s     = div_quo_s;
            step_result_s = div_pick(op_r, div_quo_s, div_rem_s, neg_r);
        end else begin
            step_acc_s    = mul_sum_s[DATA_WIDTH:1];
            step_lo_s     = {mul_sum_s[0], lo_r[DATA_WIDTH-1:1]};
            step_result_s = mul_pick(op_r, {step_acc_s, step_lo_s}, neg_r);
        end
    end

    // FSM next-state: special cases and fast multiply skip the iteration phase.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nx_s = (div0_s || ovf_s || fast_s) ? ST_FINISH : ST_CALC;
                else          state_nx_s = ST_IDLE;
            end
            ST_CALC: begin
                if (bus.FLUSH_i)            state_nx_s = ST_IDLE;
                else if (cnt_r == CNT_ZERO) state_nx_s = ST_FINISH;
                else                        state_nx_s = ST_CALC;
            end
            ST_FINISH: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge RST_N_i) begin
        if (!RST_N_i) state_r <= ST_IDLE;
        else          state_r <= state_nx_s;
    end

    // Datapath and registered outputs; RESULT_o only changes on entry to FINISH.
    always_ff @(posedge clk or negedge RST_N_i) begin
        if (!RST_N_i) begin
            op_r     <= 3'b000;
            rd_r     <= {ADDRESS_WIDTH{1'b0}};
            acc_r    <= {DATA_WIDTH{1'b0}};
            lo_r     <= {DATA_WIDTH{1'b0}};
            opb_r    <= {DATA_WIDTH{1'b0}};
            result_r <= {DATA_WIDTH{1'b0}};
            cnt_r    <= CNT_ZERO;
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            we_r     <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= (state_nx_s == ST_FINISH);
            we_r   <= (state_nx_s == ST_FINISH) && (rd_nx_s != {ADDRESS_WIDTH{1'b0}});
            rd_r   <= rd_nx_s;
            if (accept_s) begin
                op_r  <= bus.FUNCT3_i;
                acc_r <= {DATA_WIDTH{1'b0}};
                lo_r  <= mag_a_s;
                opb_r <= mag_b_s;
                neg_r <= neg_s;
                cnt_r <= CNT_LAST;
                if (div0_s || ovf_s || fast_s) result_r <= early_result_s;
            end else if ((state_r == ST_CALC) && !bus.FLUSH_i) begin
                acc_r <= step_acc_s;
                lo_r  <= step_lo_s;
                if (cnt_r == CNT_ZERO) result_r <= step_result_s;
                else                   cnt_r    <= cnt_r - CNT_ONE;
            end
        end
    end

    assign bus.BUSY_o    = busy_r;
    assign bus.DONE_o    = done_r;
    assign bus.WE_o      = we_r;
    assign bus.RESULT_o  = result_r;
    assign bus.RD_ADDR_o = rd_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, control scenarios and
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    int          vectors = 0;
    int          miscompares = 0;
    logic [2:0]  f3;
    logic [31:0] a, b, prev;
    logic [4:0]  rd;
    int          stray;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk     (clk),
        .RST_N_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int ix, iy;
        longint sx, sy, p;
        longint unsigned ux, uy, pu;
        ix = x; iy = y; sx = ix; sy = iy;
        ux = {32'h0, x}; uy = {32'h0, y};
        case (op)
            3'b000: begin p = sx * sy; return p[31:0]; end
            3'b001: begin p = sx * sy; return p[63:32]; end
            3'b010: begin p = sx * longint'(uy); return p[63:32]; end
            3'b011: begin pu = ux * uy; return pu[63:32]; end
            3'b100: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ix / iy;
            end
            3'b101: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'b110: begin
                if (y == 32'h0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return ix % iy;
            end
            default: begin
                if (y == 32'h0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op[2]) begin
            if (y == 32'h0) return 1;
            if ((op == 3'b100 || op == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Issue one operation from an idle cycle (called #1 after a rising edge) and check write-back.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] dst, input bit poke);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        exp_res = ref_result(op, x, y);
        exp_lat = ref_latency(op, x, y);
        bus.FUNCT3_i  = op;
        bus.OP_A_i    = x;
        bus.OP_B_i    = y;
        bus.RD_ADDR_i = dst;
        bus.START_i   = 1'b1;
        @(posedge clk); #1;
        bus.START_i   = 1'b0;
        bus.OP_A_i    = $urandom();
        bus.OP_B_i    = $urandom();
        bus.FUNCT3_i  = 3'($urandom_range(0, 7));
        bus.RD_ADDR_i = 5'($urandom_range(0, 31));
        check({tag, " busy_rise"}, 32'(bus.BUSY_o), 32'd1);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.DONE_o === 1'b1) begin
                lat = n;
                break;
            end
            bus.START_i = poke && (n >= 2) && (n <= 20);
            @(posedge clk); #1;
        end
        bus.START_i = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, bus.RESULT_o, exp_res);
        check({tag, " we"}, 32'(bus.WE_o), 32'(dst != 5'd0));
        check({tag, " rd_addr"}, 32'(bus.RD_ADDR_o), 32'(dst));
        check({tag, " busy_finish"}, 32'(bus.BUSY_o), 32'd1);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(bus.DONE_o), 32'd0);
        check({tag, " busy_fall"}, 32'(bus.BUSY_o), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.START_i   = 1'b0;
        bus.FLUSH_i   = 1'b0;
        bus.FUNCT3_i  = 3'b000;
        bus.OP_A_i    = 32'h0;
        bus.OP_B_i    = 32'h0;
        bus.RD_ADDR_i = 5'd0;
        #1;
        check("reset busy", 32'(bus.BUSY_o), 32'd0);
        check("reset done", 32'(bus.DONE_o), 32'd0);
        check("reset we", 32'(bus.WE_o), 32'd0);
        check("reset result", bus.RESULT_o, 32'h0);
        check("reset rd_addr", 32'(bus.RD_ADDR_o), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
        run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0);
        run_op("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
        run_op("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b0);
        run_op("div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0);
        run_op("rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd11, 1'b0);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd12, 1'b0);
        run_op("div_5_0", 3'b100, 32'd5, 32'd0, 5'd13, 1'b0);
        run_op("remu_5_0", 3'b111, 32'd5, 32'd0, 5'd14, 1'b0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0);
        run_op("rd0_start_busy", 3'b101, 32'd1000, 32'd3, 5'd0, 1'b1);

        // Flush in the tenth cycle of a divide.
        prev          = bus.RESULT_o;
        bus.FUNCT3_i  = 3'b100;
        bus.OP_A_i    = 32'd1000;
        bus.OP_B_i    = 32'd3;
        bus.RD_ADDR_i = 5'd7;
        bus.START_i   = 1'b1;
        @(posedge clk); #1;
        bus.START_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.FLUSH_i = 1'b1;
        @(posedge clk); #1;
        bus.FLUSH_i = 1'b0;
        check("flush busy", 32'(bus.BUSY_o), 32'd0);
        check("flush done", 32'(bus.DONE_o), 32'd0);
        check("flush we", 32'(bus.WE_o), 32'd0);
        check("flush result_hold", bus.RESULT_o, prev);
        stray = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.DONE_o !== 1'b0 || bus.WE_o !== 1'b0) stray++;
            @(posedge clk); #1;
        end
        check("flush no_late_done", 32'(stray), 32'd0);

        // Flush and start together in IDLE: request must be dropped.
        bus.FUNCT3_i  = 3'b100;
        bus.OP_A_i    = 32'd5;
        bus.OP_B_i    = 32'd0;
        bus.RD_ADDR_i = 5'd3;
        bus.START_i   = 1'b1;
        bus.FLUSH_i   = 1'b1;
        @(posedge clk); #1;
        bus.START_i = 1'b0;
        bus.FLUSH_i = 1'b0;
        check("flush_start busy", 32'(bus.BUSY_o), 32'd0);
        check("flush_start done", 32'(bus.DONE_o), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = $urandom();
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 15);
                default: b = b;
            endcase
            rd = 5'($urandom_range(0, 31));
            run_op("rand", f3, a, b, rd, i[0]);
        end

        // Asynchronous reset in the middle of an iterative divide.
        bus.FUNCT3_i  = 3'b101;
        bus.OP_A_i    = 32'd12345;
        bus.OP_B_i    = 32'd17;
        bus.RD_ADDR_i = 5'd9;
        bus.START_i   = 1'b1;
        @(posedge clk); #1;
        bus.START_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(bus.BUSY_o), 32'd0);
        check("midreset done", 32'(bus.DONE_o), 32'd0);
        check("midreset we", 32'(bus.WE_o), 32'd0);
        check("midreset result", bus.RESULT_o, 32'h0);
        check("midreset rd_addr", 32'(bus.RD_ADDR_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_reset", 3'b110, 32'hFFFF_FF9C, 32'd7, 5'd31, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
